// File: rtl/frac_search_ctrl.sv
// Sequencer for the 8x8 QPEL fractional search: fetches ROWS filter/ref rows,
// streams them as one unbroken burst, then returns the search result as a pulse.
module frac_search_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int ROWS        = 8,
  parameter int RESULT_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] blk_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic              abort,
  output logic              busy,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [63:0]       rd_filter_data,
  input  logic [63:0]       rd_ref_data,
  output logic [63:0]       fs_filter_pix,
  output logic [63:0]       fs_ref_pix,
  output logic              fs_input_ready,
  input  logic [2:0]        fs_mvx,
  input  logic [2:0]        fs_mvy,
  output logic              mv_valid,
  output logic [2:0]        mv_x,
  output logic [2:0]        mv_y
);
  localparam int CW = $clog2(ROWS + 1);
  localparam int IW = $clog2(ROWS);
  localparam int GW = $clog2(RESULT_WAIT + 1);

  typedef enum logic [2:0] {IDLE, FETCH, STREAM, GAP, DONE, DRAIN} state_t;

  state_t                  state, state_nxt, kill_state;
  logic [ADDR_W-1:0]       addr, stride_q;
  logic [CW-1:0]           req_cnt, wr_cnt, out_cnt, out_cnt_nxt;
  logic [IW-1:0]           str_cnt;
  logic [GW-1:0]           gap_cnt;
  logic [ROWS-1:0][63:0]   filt_buf, ref_buf;
  logic                    acc, rsp, accept, cap;

  assign rd_req      = (state == FETCH) && (req_cnt < CW'(ROWS));
  assign rd_addr     = rd_req ? addr : '0;
  assign acc         = rd_req && rd_ack;
  // Returns with nothing outstanding are stray and dropped everywhere.
  assign rsp         = rd_valid && (out_cnt != '0);
  assign out_cnt_nxt = out_cnt + CW'(acc) - CW'(rsp);
  assign accept      = (state == IDLE) && start && !abort;
  assign cap         = (state == GAP) && !abort && (gap_cnt == GW'(RESULT_WAIT - 1));
  // An abort may race a just-accepted read, so decide on the post-cycle count.
  assign kill_state  = (out_cnt_nxt == '0) ? IDLE : DRAIN;

  assign busy           = (state != IDLE);
  assign fs_input_ready = (state == STREAM);
  assign fs_filter_pix  = fs_input_ready ? filt_buf[str_cnt] : '0;
  assign fs_ref_pix     = fs_input_ready ? ref_buf[str_cnt] : '0;
  assign mv_valid       = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept) state_nxt = FETCH;
      FETCH:  if (abort) state_nxt = kill_state;
              else if (rsp && wr_cnt == CW'(ROWS - 1)) state_nxt = STREAM;
      STREAM: if (abort) state_nxt = kill_state;
              else if (str_cnt == IW'(ROWS - 1)) state_nxt = GAP;
      GAP:    if (abort) state_nxt = kill_state;
              else if (cap) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      DRAIN:  if (out_cnt_nxt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      addr     <= '0;
      stride_q <= '0;
      req_cnt  <= '0;
      wr_cnt   <= '0;
      out_cnt  <= '0;
      str_cnt  <= '0;
      gap_cnt  <= '0;
      mv_x     <= '0;
      mv_y     <= '0;
    end else begin
      state   <= state_nxt;
      out_cnt <= accept ? '0 : out_cnt_nxt;
      if (accept) begin
        addr     <= blk_addr;
        stride_q <= stride;
        req_cnt  <= '0;
        wr_cnt   <= '0;
        str_cnt  <= '0;
        gap_cnt  <= '0;
      end else begin
        if (acc) begin
          addr    <= addr + stride_q;
          req_cnt <= req_cnt + CW'(1);
        end
        if (state == FETCH && rsp) wr_cnt <= wr_cnt + CW'(1);
        if (state == STREAM) str_cnt <= str_cnt + IW'(1);
        if (state == GAP) gap_cnt <= gap_cnt + GW'(1);
        if (cap) begin
          mv_x <= fs_mvx;
          mv_y <= fs_mvy;
        end
      end
    end
  end

  // Row storage is data only; it is never observed outside STREAM.
  always_ff @(posedge clk) begin
    if (state == FETCH && rsp) begin
      filt_buf[wr_cnt[IW-1:0]] <= rd_filter_data;
      ref_buf[wr_cnt[IW-1:0]]  <= rd_ref_data;
    end
  end
endmodule

// File: tb/tb_frac_search_ctrl.sv
// Directed bench for frac_search_ctrl: a latency/ack-configurable line-memory
// responder plus event logs checked against hand-derived addresses and timing.
module tb_frac_search_ctrl;
  logic        clk, reset, start, abort;
  logic [15:0] blk_addr, stride;
  logic        busy, rd_req, rd_ack, rd_valid;
  logic [15:0] rd_addr;
  logic [63:0] rd_filter_data, rd_ref_data, fs_filter_pix, fs_ref_pix;
  logic        fs_input_ready, mv_valid;
  logic [2:0]  fs_mvx, fs_mvy, mv_x, mv_y;

  frac_search_ctrl #(.ADDR_W(16), .ROWS(8), .RESULT_WAIT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .blk_addr(blk_addr), .stride(stride),
    .abort(abort), .busy(busy), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_filter_data(rd_filter_data), .rd_ref_data(rd_ref_data),
    .fs_filter_pix(fs_filter_pix), .fs_ref_pix(fs_ref_pix), .fs_input_ready(fs_input_ready),
    .fs_mvx(fs_mvx), .fs_mvy(fs_mvy), .mv_valid(mv_valid), .mv_x(mv_x), .mv_y(mv_y));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_f(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5A5A, a + 16'h1234};
  endfunction
  function automatic logic [63:0] mem_r(input logic [15:0] a);
    return {a ^ 16'hC3C3, a + 16'h0101, ~a ^ 16'h0F0F, a};
  endfunction

  // Responder and monitor: acts on the falling edge, DUT samples on the rising one.
  typedef struct {logic [15:0] a; int due;} rd_t;
  rd_t         rq[$];
  logic [15:0] acc_log[$];
  int          acc_cyc[$], str_cyc[$], mv_cyc[$];
  logic [63:0] str_f[$], str_r[$];
  logic [5:0]  mv_log[$];
  int          ret_cnt = 0, lat = 1;
  bit          ack_en = 1'b1, ack_mode = 1'b0;

  always @(negedge clk) begin
    rd_t r;
    rd_valid = 1'b0;
    rd_filter_data = '0;
    rd_ref_data = '0;
    if (!reset) begin
      rq.delete();
      rd_ack = 1'b0;
    end else begin
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        rd_valid = 1'b1;
        rd_filter_data = mem_f(r.a);
        rd_ref_data = mem_r(r.a);
        ret_cnt++;
      end
      rd_ack = ack_en && (!ack_mode || (cyc % 2 == 0));
      if (rd_req && rd_ack) begin
        rq.push_back('{a: rd_addr, due: cyc + lat});
        acc_log.push_back(rd_addr);
        acc_cyc.push_back(cyc);
      end
      if (fs_input_ready) begin
        str_f.push_back(fs_filter_pix);
        str_r.push_back(fs_ref_pix);
        str_cyc.push_back(cyc);
      end
      if (mv_valid) begin
        mv_log.push_back({mv_x, mv_y});
        mv_cyc.push_back(cyc);
      end
    end
  end

  int t0;
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] b, input logic [15:0] s);
    acc_log.delete(); acc_cyc.delete(); str_f.delete(); str_r.delete();
    str_cyc.delete(); mv_log.delete(); mv_cyc.delete(); ret_cnt = 0;
    blk_addr = b; stride = s; start = 1'b1; t0 = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (mv_log.size() == 0 && n < 200) begin step(); n++; end
    chk({tag, "_timeout"}, 64'(n < 200), 64'd1);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!fs_input_ready && n < 200) begin step(); n++; end
    chk({tag, "_rdy_timeout"}, 64'(n < 200), 64'd1);
  endtask

  task automatic check_job(input string tag, input logic [15:0] b, input logic [15:0] s,
                           input logic [2:0] ex, input logic [2:0] ey);
    logic [15:0] a;
    logic [63:0] gf, gr, ga;
    int gc;
    chk({tag, "_nreq"}, 64'(acc_log.size()), 64'd8);
    chk({tag, "_nbeat"}, 64'(str_f.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      a = b + 16'(i) * s;
      ga = '0; gf = '0; gr = '0; gc = -1;
      if (i < acc_log.size()) ga = 64'(acc_log[i]);
      if (i < str_f.size()) begin gf = str_f[i]; gr = str_r[i]; gc = str_cyc[i] - str_cyc[0]; end
      chk($sformatf("%s_addr%0d", tag, i), ga, 64'(a));
      chk($sformatf("%s_filt%0d", tag, i), gf, mem_f(a));
      chk($sformatf("%s_ref%0d", tag, i), gr, mem_r(a));
      chk($sformatf("%s_contig%0d", tag, i), 64'(gc), 64'(i));
    end
    chk({tag, "_nmv"}, 64'(mv_log.size()), 64'd1);
    chk({tag, "_mv"}, 64'(mv_log.size() > 0 ? mv_log[0] : 6'h0), 64'({ex, ey}));
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rdreq"}, 64'(rd_req), 64'd0);
    chk({tag, "_rdaddr"}, 64'(rd_addr), 64'd0);
    chk({tag, "_ready"}, 64'(fs_input_ready), 64'd0);
    chk({tag, "_fpix"}, fs_filter_pix, 64'd0);
    chk({tag, "_rpix"}, fs_ref_pix, 64'd0);
    chk({tag, "_mvv"}, 64'(mv_valid), 64'd0);
    chk({tag, "_mv"}, 64'({mv_x, mv_y}), 64'd0);
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; abort = 1'b0; blk_addr = '0; stride = '0;
    fs_mvx = '0; fs_mvy = '0;
    repeat (2) step();
    check_quiet("rst");
    reset = 1'b1;
    step();

    // Basic job with exact latency
    fs_mvx = 3'b110; fs_mvy = 3'b011;
    start_job(16'h0100, 16'h0040);
    wait_done("basic");
    check_job("basic", 16'h0100, 16'h0040, 3'b110, 3'b011);
    chk("basic_req_first", 64'(acc_cyc.size() > 0 ? acc_cyc[0] - t0 : -1), 64'd1);
    chk("basic_req_last", 64'(acc_cyc.size() > 7 ? acc_cyc[7] - t0 : -1), 64'd8);
    chk("basic_rdy_first", 64'(str_cyc.size() > 0 ? str_cyc[0] - t0 : -1), 64'd10);
    chk("basic_mv_cyc", 64'(mv_cyc.size() > 0 ? mv_cyc[0] - t0 : -1), 64'd19);
    step();
    chk("basic_idle", 64'(busy), 64'd0);

    // Back-pressure: ack toggling, latency 3
    ack_mode = 1'b1; lat = 3; fs_mvx = 3'b001; fs_mvy = 3'b101;
    start_job(16'h1000, 16'h0008);
    wait_done("bp");
    check_job("bp", 16'h1000, 16'h0008, 3'b001, 3'b101);
    step();

    // Address wrap
    ack_mode = 1'b0; lat = 1; fs_mvx = 3'b111; fs_mvy = 3'b100;
    start_job(16'hFFC0, 16'h0020);
    wait_done("wrap");
    check_job("wrap", 16'hFFC0, 16'h0020, 3'b111, 3'b100);
    step();

    // Abort in FETCH after 5 accepted, 2 returned
    lat = 3; fs_mvx = 3'b010; fs_mvy = 3'b010;
    start_job(16'h0200, 16'h0010);
    n = 0;
    while (acc_log.size() < 5 && n < 50) begin step(); n++; end
    chk("ab_acc5", 64'(acc_log.size()), 64'd5);
    chk("ab_ret2", 64'(ret_cnt), 64'd2);
    abort = 1'b1; ack_en = 1'b0;
    step();
    abort = 1'b0; ack_en = 1'b1;
    chk("ab_drain_busy", 64'(busy), 64'd1);
    chk("ab_drain_rdreq", 64'(rd_req), 64'd0);
    chk("ab_drain_ready", 64'(fs_input_ready), 64'd0);
    n = 0;
    while (busy && n < 50) begin step(); n++; end
    chk("ab_idle", 64'(busy), 64'd0);
    chk("ab_all_ret", 64'(ret_cnt), 64'd5);
    chk("ab_q_empty", 64'(rq.size()), 64'd0);
    chk("ab_nmv", 64'(mv_log.size()), 64'd0);
    chk("ab_mv_hold", 64'({mv_x, mv_y}), 64'({3'b111, 3'b100}));
    lat = 1;
    start_job(16'h0300, 16'h0008);
    wait_done("post_ab");
    check_job("post_ab", 16'h0300, 16'h0008, 3'b010, 3'b010);
    step();

    // start during STREAM, then start+abort together in IDLE
    fs_mvx = 3'b101; fs_mvy = 3'b110;
    start_job(16'h0400, 16'h0100);
    wait_ready("ign");
    blk_addr = 16'h7777; start = 1'b1;
    step();
    start = 1'b0;
    wait_done("ign");
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    repeat (4) step();
    chk("ign_busy", 64'(busy), 64'd0);
    check_job("ign", 16'h0400, 16'h0100, 3'b101, 3'b110);

    // Reset during STREAM
    start_job(16'h0500, 16'h0001);
    wait_ready("rs");
    step();
    reset = 1'b0;
    #1;
    check_quiet("rs_mid");
    step();
    reset = 1'b1;
    step();
    fs_mvx = 3'b011; fs_mvy = 3'b001;
    start_job(16'h0600, 16'h0020);
    wait_done("post_rst");
    check_job("post_rst", 16'h0600, 16'h0020, 3'b011, 3'b001);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
